pipe_phy_responder: RTL and testbench

PIPE_PHY_RESPONDER -- requirements
Module: pipe_phy_responder

---
 rtl/pipe_phy_responder.sv | 155 +++++++++++++++
 tb/tb_pipe_phy_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_phy_responder.sv
// PIPE PHY behavioural responder: answers receiver detect, power-down
// and rate-change requests from a MAC with PhyStatus/RxStatus handshakes.
module pipe_phy_responder #(
  parameter int LANESNUMBER    = 16,
  parameter int DETECT_LATENCY = 4,
  parameter int RATE_LATENCY   = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [LANESNUMBER-1:0]   TxDetectRx_Loopback,
  input  logic [LANESNUMBER-1:0]   TxElecIdle,
  input  logic [4*LANESNUMBER-1:0] PowerDown,
  input  logic [3:0]               Rate,
  input  logic                     PclkChangeAck,
  input  logic [LANESNUMBER-1:0]   RxPresent,
  output logic [LANESNUMBER-1:0]   PhyStatus,
  output logic [3*LANESNUMBER-1:0] RxStatus,
  output logic                     PclkChangeOk,
  output logic                     Busy
);

  localparam int L  = LANESNUMBER;
  localparam int DL = (DETECT_LATENCY < 1) ? 1 : DETECT_LATENCY;
  localparam int RL = (RATE_LATENCY < 1) ? 1 : RATE_LATENCY;
  localparam int MX = (DL > RL) ? ((DL > 2) ? DL : 2)
                                : ((RL > 2) ? RL : 2);
  localparam int CW = $clog2(MX + 1);

  typedef enum logic [2:0] {
    RST_HOLD, IDLE, DETECT, DETECT_DONE,
    PD_CHANGE, RATE_WAIT, RATE_ACK
  } state_t;

  state_t           state, stateN;
  logic [CW-1:0]    cnt, cntN;
  logic [L-1:0]     mask, maskN;
  logic [4*L-1:0]   pdQ, pdN;
  logic [3:0]       rateQ, rateN;
  logic [L-1:0]     phyN;
  logic [3*L-1:0]   rxN;
  logic             okN, busyN;
  logic [L-1:0]     detReq;

  assign detReq = TxDetectRx_Loopback & TxElecIdle;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state        <= RST_HOLD;
      cnt          <= '0;
      mask         <= '0;
      pdQ          <= '0;
      rateQ        <= '0;
      PhyStatus    <= '1;
      RxStatus     <= '0;
      PclkChangeOk <= 1'b0;
      Busy         <= 1'b1;
    end else begin
      state        <= stateN;
      cnt          <= cntN;
      mask         <= maskN;
      pdQ          <= pdN;
      rateQ        <= rateN;
      PhyStatus    <= phyN;
      RxStatus     <= rxN;
      PclkChangeOk <= okN;
      Busy         <= busyN;
    end
  end

  always_comb begin
    stateN = state;
    cntN   = cnt;
    maskN  = mask;
    pdN    = pdQ;
    rateN  = rateQ;
    phyN   = '0;
    rxN    = '0;
    okN    = 1'b0;
    unique case (state)
      RST_HOLD: begin
        phyN = '1;
        if (cnt == CW'(1)) begin
          stateN = IDLE;
          cntN   = '0;
          pdN    = PowerDown;
          rateN  = Rate;
          phyN   = '0;
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      IDLE: begin
        cntN = '0;
        // rate beats power-down beats detect
        if (Rate != rateQ) begin
          stateN = RATE_WAIT;
        end else if (PowerDown != pdQ) begin
          stateN = PD_CHANGE;
        end else if (|detReq) begin
          stateN = DETECT;
          maskN  = detReq;
        end
      end
      DETECT: begin
        if (cnt == CW'(DL - 1)) begin
          stateN = DETECT_DONE;
          cntN   = '0;
          phyN   = mask;
          for (int i = 0; i < L; i++) begin
            if (mask[i] && RxPresent[i]) rxN[3*i +: 3] = 3'b011;
          end
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      DETECT_DONE: begin
        if (TxDetectRx_Loopback == '0) begin
          stateN = IDLE;
          maskN  = '0;
        end
      end
      PD_CHANGE: begin
        if (cnt == CW'(1)) begin
          stateN = IDLE;
          cntN   = '0;
          phyN   = '1;
          pdN    = PowerDown;
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      RATE_WAIT: begin
        if (cnt == CW'(RL - 1)) begin
          stateN = RATE_ACK;
          cntN   = '0;
          okN    = 1'b1;
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      RATE_ACK: begin
        okN = 1'b1;
        if (PclkChangeAck) begin
          stateN = IDLE;
          okN    = 1'b0;
          phyN   = '1;
          rateN  = Rate;
        end
      end
      default: stateN = RST_HOLD;
    endcase
    busyN = (stateN != IDLE);
  end

endmodule

// File: tb/tb_pipe_phy_responder.sv
// Directed bench for pipe_phy_responder: reset, detect, rate,
// power-down and mid-operation reset sequences.
module tb_pipe_phy_responder;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] TxDetectRx_Loopback;
  logic [15:0] TxElecIdle;
  logic [63:0] PowerDown;
  logic [3:0]  Rate;
  logic        PclkChangeAck;
  logic [15:0] RxPresent;
  logic [15:0] PhyStatus;
  logic [47:0] RxStatus;
  logic        PclkChangeOk;
  logic        Busy;

  int passCnt = 0;
  int totalCnt = 0;

  pipe_phy_responder dut (
    .CLK                (CLK),
    .reset              (reset),
    .TxDetectRx_Loopback(TxDetectRx_Loopback),
    .TxElecIdle         (TxElecIdle),
    .PowerDown          (PowerDown),
    .Rate               (Rate),
    .PclkChangeAck      (PclkChangeAck),
    .RxPresent          (RxPresent),
    .PhyStatus          (PhyStatus),
    .RxStatus           (RxStatus),
    .PclkChangeOk       (PclkChangeOk),
    .Busy               (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    reset               = 1'b0;
    TxDetectRx_Loopback = '0;
    TxElecIdle          = '0;
    PowerDown           = '0;
    Rate                = 4'd0;
    PclkChangeAck       = 1'b0;
    RxPresent           = '0;

    // reset state
    step(2);
    chk("rst_phy", 64'(PhyStatus), 64'hFFFF);
    chk("rst_rx", 64'(RxStatus), 64'h0);
    chk("rst_ok", 64'(PclkChangeOk), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h1);
    reset = 1'b1;
    step(1);
    chk("hold1_phy", 64'(PhyStatus), 64'hFFFF);
    chk("hold1_busy", 64'(Busy), 64'h1);
    step(1);
    chk("idle_phy", 64'(PhyStatus), 64'h0);
    chk("idle_busy", 64'(Busy), 64'h0);

    // detect, lane 0 present
    TxElecIdle          = 16'hFFFF;
    RxPresent           = 16'hFFFF;
    TxDetectRx_Loopback = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("det1_wait_phy", 64'(PhyStatus), 64'h0);
    end
    step(1);
    chk("det1_phy", 64'(PhyStatus), 64'h0001);
    chk("det1_rx", 64'(RxStatus), 64'h3);
    chk("det1_busy", 64'(Busy), 64'h1);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("det1_held_phy", 64'(PhyStatus), 64'h0);
      chk("det1_held_rx", 64'(RxStatus), 64'h0);
    end
    chk("det1_held_busy", 64'(Busy), 64'h1);
    TxDetectRx_Loopback = '0;
    step(1);
    chk("det1_done_busy", 64'(Busy), 64'h0);

    // detect, all lanes absent
    RxPresent           = 16'h0000;
    TxDetectRx_Loopback = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("det2_wait_phy", 64'(PhyStatus), 64'h0);
    end
    step(1);
    chk("det2_phy", 64'(PhyStatus), 64'hFFFF);
    chk("det2_rx", 64'(RxStatus), 64'h0);
    step(3);
    chk("det2_held_phy", 64'(PhyStatus), 64'h0);
    TxDetectRx_Loopback = '0;
    step(1);
    chk("det2_done_busy", 64'(Busy), 64'h0);

    // rate change 0 -> 1 with delayed ack
    Rate = 4'd1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("rate_wait_ok", 64'(PclkChangeOk), 64'h0);
    end
    step(1);
    chk("rate_ok", 64'(PclkChangeOk), 64'h1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rate_hold_ok", 64'(PclkChangeOk), 64'h1);
      chk("rate_hold_phy", 64'(PhyStatus), 64'h0);
    end
    PclkChangeAck = 1'b1;
    step(1);
    PclkChangeAck = 1'b0;
    chk("rate_ack_ok", 64'(PclkChangeOk), 64'h0);
    chk("rate_ack_phy", 64'(PhyStatus), 64'hFFFF);
    chk("rate_ack_busy", 64'(Busy), 64'h0);
    step(1);
    chk("rate_post_phy", 64'(PhyStatus), 64'h0);
    chk("rate_post_busy", 64'(Busy), 64'h0);

    // simultaneous power-down and rate change: rate first
    PowerDown = 64'h2222_2222_2222_2222;
    Rate      = 4'd2;
    step(8);
    chk("both_wait_ok", 64'(PclkChangeOk), 64'h0);
    step(1);
    chk("both_ok", 64'(PclkChangeOk), 64'h1);
    PclkChangeAck = 1'b1;
    step(1);
    PclkChangeAck = 1'b0;
    chk("both_rate_phy", 64'(PhyStatus), 64'hFFFF);
    chk("both_rate_ok", 64'(PclkChangeOk), 64'h0);
    step(1);
    chk("both_pd_phy0", 64'(PhyStatus), 64'h0);
    chk("both_pd_busy", 64'(Busy), 64'h1);
    step(1);
    chk("both_pd_phy1", 64'(PhyStatus), 64'h0);
    step(1);
    chk("both_pd_pulse", 64'(PhyStatus), 64'hFFFF);
    chk("both_pd_idle", 64'(Busy), 64'h0);
    step(1);
    chk("both_pd_after", 64'(PhyStatus), 64'h0);
    chk("both_pd_stay", 64'(Busy), 64'h0);

    // reset during RATE_ACK
    Rate = 4'd3;
    step(9);
    chk("rr_ok", 64'(PclkChangeOk), 64'h1);
    #2 reset = 1'b0;
    #1;
    chk("rr_ok_low", 64'(PclkChangeOk), 64'h0);
    chk("rr_phy", 64'(PhyStatus), 64'hFFFF);
    chk("rr_busy", 64'(Busy), 64'h1);
    step(2);
    reset = 1'b1;
    step(1);
    chk("rr_hold_phy", 64'(PhyStatus), 64'hFFFF);
    step(1);
    chk("rr_idle_phy", 64'(PhyStatus), 64'h0);
    chk("rr_idle_busy", 64'(Busy), 64'h0);
    step(3);
    chk("rr_quiet_busy", 64'(Busy), 64'h0);
    chk("rr_quiet_ok", 64'(PclkChangeOk), 64'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
